// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential N x N matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_e;

  // Wide enough that an N-term sum of DW x DW products never wraps.
  function automatic int acc_w_default(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // LSB of element (i,j) in a flattened row-major matrix of n columns and w-bit elements.
  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate unit: one extended DW x DW product added to the running sum per enabled cycle.
module matmul_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    a_elem,
  input  logic [DW-1:0]    b_elem,
  input  logic             signed_mode,
  input  logic             clear,
  input  logic             en,
  output logic [ACC_W-1:0] acc_next
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;

  // Sign- or zero-extend first so the ACC_W-bit product wraps correctly in both modes.
  always_comb begin
    a_ext    = {{(ACC_W-DW){signed_mode & a_elem[DW-1]}}, a_elem};
    b_ext    = {{(ACC_W-DW){signed_mode & b_elem[DW-1]}}, b_elem};
    acc_next = (clear ? '0 : acc_q) + a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier: captures A and B, walks i/j/k through one shared MAC,
// and holds the product behind a valid/ready handshake.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = acc_w_default(DW, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [N*N*DW-1:0]    a_flat,
  input  logic [N*N*DW-1:0]    b_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*N*ACC_W-1:0] result,
  output logic                 busy
);

  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [N*N*DW-1:0] a_q, b_q;
  logic            sm_q;
  logic [DW-1:0]   a_elem, b_elem;
  logic [ACC_W-1:0] acc_next;
  logic            accept, mac_en, wr_en;
  int              wr_idx;

  assign accept = in_valid && (state_q == IDLE);
  assign mac_en = (state_q == MAC);
  assign wr_en  = mac_en && (k_q == LAST);
  assign wr_idx = elem_lsb(int'(i_q), int'(j_q), N, 1);
  assign a_elem = a_q[elem_lsb(int'(i_q), int'(k_q), N, DW) +: DW];
  assign b_elem = b_q[elem_lsb(int'(k_q), int'(j_q), N, DW) +: DW];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = mac_en;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST) begin
          k_d = '0;
          j_d = j_q + 1'b1;
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      if (accept) begin
        a_q  <= a_flat;
        b_q  <= b_flat;
        sm_q <= signed_mode;
      end
    end
  end

  matmul_mac #(
    .DW   (DW),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_elem     (a_elem),
    .b_elem     (b_elem),
    .signed_mode(sm_q),
    .clear      (k_q == '0),
    .en         (mac_en),
    .acc_next   (acc_next)
  );

  // Each product element keeps its value until its own slot is rewritten by the next run.
  genvar gi;
  generate
    for (gi = 0; gi < N * N; gi++) begin : g_c
      logic [ACC_W-1:0] c_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          c_q <= '0;
        end else if (wr_en && (wr_idx == gi)) begin
          c_q <= acc_next;
        end
      end
      assign result[gi*ACC_W +: ACC_W] = c_q;
    end
  endgenerate

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Parametrised sequential N×N matrix multiplier. It is the next generation of the team's combinational 3×3 8-bit matrix calculator. It accepts two flattened row-major matrices through a valid/ready handshake and computes the product with a single time-shared multiply-accumulate unit, one MAC per cycle. It presents the flattened product through a second valid/ready handshake. It supports signed and unsigned operands and sits between the operand loader and the result display/readout logic.

## Interface
- N, 3: matrix dimension (N ≥ 2).
- DW, 8: operand element width.
- ACC_W, 2*DW+$clog2(N): result element width; products and sums wrap modulo 2^ACC_W.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands A, B and signed_mode valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured at accept.
- a_flat  in  N*N*DW  matrix A; element (i,j) at bits [(i*N+j)*DW +: DW].
- b_flat  in  N*N*DW  matrix B; same packing.
- out_valid  out  1  result holds a complete product.
- out_ready  in  1  consumer accepts result.
- result  out  N*N*ACC_W  product C; element (i,j) at bits [(i*N+j)*ACC_W +: ACC_W].
- busy  out  1  high in MAC state.

## Operation
- FSM states: IDLE, MAC, DONE.
  - IDLE → MAC on an edge with in_valid && in_ready. On that edge: capture a_flat, b_flat, signed_mode into internal registers; clear i, j, k.
  - MAC: each edge performs acc_next = (k==0 ? 0 : acc) + ext(A[i][k]) * ext(B[k][j]). ext = sign-extend to ACC_W if signed_mode, else zero-extend.
    - k increments; at k==N-1: write acc_next to C[i][j], reset k to 0, advance j (then i).
    - The edge that writes C[N-1][N-1] moves the FSM to DONE.
  - DONE → IDLE on an edge with out_valid && out_ready.
- in_valid is ignored outside IDLE. Inputs may change freely after accept; the captured copy is used.
- result register keeps its last value after handoff, until overwritten element-by-element during the next MAC run.
- result is only guaranteed coherent while out_valid is high.
- Arithmetic truncates to ACC_W bits, no saturation and no overflow flag. With default ACC_W no overflow is possible for either mode.

## Timing
- Reset (rst_n low at an edge): state IDLE; in_ready=1 on the following cycle; out_valid=0; busy=0; result=0; all counters and acc = 0.
- Reset mid-MAC or in DONE aborts the operation with no out_valid pulse. Reset overrides every simultaneous handshake.
- Latency: out_valid rises exactly N³ edges after the accept edge (27 for N=3). busy is high for those N³ cycles.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered state.
- Throughput: one product per N³+2 cycles when out_ready is held high. That is accept, N³ MAC edges, a handoff edge, and back in IDLE.
- Backpressure: out_valid and result are held stable indefinitely while out_ready is low.
- out_ready is ignored when out_valid is low. in_valid asserted during DONE is not accepted until IDLE.

## Structure
- Package matmul_pkg holds:
  - the state enum (IDLE, MAC, DONE);
  - a function elem_lsb(i, j, w) returning (i*N+j)*w for slicing;
  - the default ACC_W expression.
- Sub-module matmul_mac holds one DW×DW multiplier with signed/unsigned extension to ACC_W, an adder, and the accumulator register. Its inputs are a_elem, b_elem, signed_mode, clear (k==0) and en. It is instantiated once.
- The top level holds the FSM, the i/j/k counters, the operand capture registers and the result register.

## Test plan
- Identity: A = I (diag 1), B = elements 1..9 row-major, unsigned, N=3 → C = B (1..9); out_valid exactly 27 cycles after accept.
- Unsigned max: all A, B = 255, N=3 → every C element = 195075 (0x2FA03, fits 18 bits).
- Signed: all A, B = 0x80 (−128), signed_mode=1 → every C = 49152. Same data with signed_mode=0 → every C = 3×128² = 49152. Then A = 0xFF (−1), B = 2, signed → every C = −6 (0x3FFFA, 18 bits).
- Backpressure/handshake:
  - out_ready low 10 cycles after out_valid → result and out_valid unchanged;
  - in_valid held high throughout → second accept only after return to IDLE, with period N³+2 when out_ready=1.
- Reset mid-op: drop rst_n at MAC cycle 12 → next cycle in_ready=1, out_valid=0, result=0. A fresh operation then completes correctly.
- Parameterisation: N=2, DW=4, A=[[15,15],[15,15]], B same, unsigned → every C = 450 (ACC_W=9); out_valid 8 cycles after accept.
